// File: rtl/video_source_gen.sv
// rtl/video_source_gen.sv - frame-timing and test-pattern pixel bus source
// Emits one fval/lval/dval frame per enable with programmable blanking and four test patterns.
module video_source_gen #(
    parameter int FRAME_W  = 640,
    parameter int FRAME_H  = 480,
    parameter int MSB_BPP  = 8,
    parameter int H_BLANK  = 16,
    parameter int V_BLANK  = 8,
    parameter int FV_LEAD  = 2,
    parameter int FV_TRAIL = 2
) (
    input  logic                       pix_clk,
    input  logic                       rst_n,
    input  logic                       enable,
    input  logic [1:0]                 pattern_sel,
    input  logic [MSB_BPP-1:0]         const_val,
    output logic                       fval,
    output logic                       lval,
    output logic                       dval,
    output logic [MSB_BPP-1:0]         pix_data,
    output logic [$clog2(FRAME_W)-1:0] pix_x,
    output logic [$clog2(FRAME_H)-1:0] pix_y,
    output logic [15:0]                frame_cnt,
    output logic                       frame_done
);

    localparam int XW   = $clog2(FRAME_W);
    localparam int YW   = $clog2(FRAME_H);
    localparam int M1   = (FRAME_W > H_BLANK) ? FRAME_W : H_BLANK;
    localparam int M2   = (V_BLANK > FV_LEAD) ? V_BLANK : FV_LEAD;
    localparam int M3   = (M2 > FV_TRAIL) ? M2 : FV_TRAIL;
    localparam int SPAN = (M1 > M3) ? M1 : M3;
    localparam int CW   = $clog2(SPAN + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_FV_LEAD, S_LINE, S_HBLANK, S_FV_TRAIL, S_VBLANK
    } state_t;

    state_t             state, state_n;
    logic [CW-1:0]      cnt, cnt_n;
    logic [YW-1:0]      line, line_n;
    logic               latch;
    logic [1:0]         pat_q, pat_eff;
    logic [MSB_BPP-1:0] const_q, const_eff;

    logic               fval_n, lval_n, done_n;
    logic [XW-1:0]      x_n;
    logic [YW-1:0]      y_n;
    logic [MSB_BPP-1:0] data_n;
    logic [15:0]        fcnt_n;
    logic               x_b3, y_b3;

    // Outputs are registered from the next-state values so they line up with the state they describe.
    always_ff @(posedge pix_clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            cnt        <= '0;
            line       <= '0;
            pat_q      <= '0;
            const_q    <= '0;
            fval       <= 1'b0;
            lval       <= 1'b0;
            dval       <= 1'b0;
            pix_data   <= '0;
            pix_x      <= '0;
            pix_y      <= '0;
            frame_cnt  <= '0;
            frame_done <= 1'b0;
        end else begin
            state      <= state_n;
            cnt        <= cnt_n;
            line       <= line_n;
            pat_q      <= pat_eff;
            const_q    <= const_eff;
            fval       <= fval_n;
            lval       <= lval_n;
            dval       <= lval_n;
            pix_data   <= data_n;
            pix_x      <= x_n;
            pix_y      <= y_n;
            frame_cnt  <= fcnt_n;
            frame_done <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        line_n  = line;
        latch   = 1'b0;
        case (state)
            S_IDLE: begin
                cnt_n = '0;
                if (enable) begin
                    state_n = S_FV_LEAD;
                    line_n  = '0;
                    latch   = 1'b1;
                end
            end
            S_FV_LEAD: begin
                if (cnt == CW'(FV_LEAD - 1)) begin
                    state_n = S_LINE;
                    cnt_n   = '0;
                end
            end
            S_LINE: begin
                if (cnt == CW'(FRAME_W - 1)) begin
                    cnt_n   = '0;
                    state_n = (line == YW'(FRAME_H - 1)) ? S_FV_TRAIL : S_HBLANK;
                end
            end
            S_HBLANK: begin
                if (cnt == CW'(H_BLANK - 1)) begin
                    state_n = S_LINE;
                    cnt_n   = '0;
                    line_n  = line + YW'(1);
                end
            end
            S_FV_TRAIL: begin
                if (cnt == CW'(FV_TRAIL - 1)) begin
                    state_n = S_VBLANK;
                    cnt_n   = '0;
                end
            end
            S_VBLANK: begin
                if (cnt == CW'(V_BLANK - 1)) begin
                    cnt_n = '0;
                    if (enable) begin
                        state_n = S_FV_LEAD;
                        line_n  = '0;
                        latch   = 1'b1;
                    end else begin
                        state_n = S_IDLE;
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                cnt_n   = '0;
                line_n  = '0;
            end
        endcase
    end

    always_comb begin
        pat_eff   = latch ? pattern_sel : pat_q;
        const_eff = latch ? const_val : const_q;
        fval_n    = (state_n == S_FV_LEAD) || (state_n == S_LINE) ||
                    (state_n == S_HBLANK) || (state_n == S_FV_TRAIL);
        lval_n    = (state_n == S_LINE);
        x_n       = lval_n ? XW'(cnt_n) : '0;
        y_n       = fval_n ? line_n : '0;
        // Shift-then-truncate yields 0 for coordinates too narrow to have bit 3.
        x_b3      = 1'(x_n >> 3);
        y_b3      = 1'(y_n >> 3);
        data_n    = '0;
        if (lval_n) begin
            case (pat_eff)
                2'd0:    data_n = MSB_BPP'(x_n);
                2'd1:    data_n = MSB_BPP'(y_n);
                2'd2:    data_n = (x_b3 ^ y_b3) ? '1 : '0;
                default: data_n = const_eff;
            endcase
        end
        done_n = (state_n == S_VBLANK) && (state != S_VBLANK);
        fcnt_n = frame_cnt + {15'd0, done_n};
    end

endmodule
